// File: rtl/ram_write_ctrl.sv
// Debounced single-shot write-port driver for the 32x4 RAM: one registered wren pulse per button press.
// Optional AUTO_INC_EN: the write address comes from an internal wrapping pointer instead of sw_addr.
module ram_write_ctrl #(
  parameter int ADDR_W          = 5,
  parameter int DATA_W          = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_n,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic [CNT_W-1:0]  write_count
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DB_PRESS,
    WRITE,
    WAIT_REL,
    DB_REL
  } state_t;

  state_t          state;
  logic [DB_W-1:0] db_cnt;
  logic            sync1;
  logic            sync2;
  logic            press_s;

  // Flops reset to 1 so a released button looks released straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  assign press_s = ~sync2;

`ifdef AUTO_INC_EN
  logic [ADDR_W-1:0] ptr;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      db_cnt      <= '0;
      wraddress   <= '0;
      data        <= '0;
      wren        <= 1'b0;
      busy        <= 1'b0;
      write_count <= '0;
`ifdef AUTO_INC_EN
      ptr         <= '0;
`endif
    end else begin
      wren <= 1'b0;
      case (state)
        IDLE: begin
          db_cnt <= '0;
          if (press_s) begin
            state <= DB_PRESS;
            busy  <= 1'b1;
          end
        end
        DB_PRESS: begin
          if (!press_s) begin
            state  <= IDLE;
            busy   <= 1'b0;
            db_cnt <= '0;
          end else if (db_cnt == DB_MAX) begin
            // Address and data are frozen on the accepting edge, not while held.
            state  <= WRITE;
            wren   <= 1'b1;
            db_cnt <= '0;
`ifdef AUTO_INC_EN
            wraddress <= ptr;
`else
            wraddress <= sw_addr;
`endif
            data   <= sw_data;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        WRITE: begin
          state       <= WAIT_REL;
          db_cnt      <= '0;
          write_count <= write_count + 1'b1;
`ifdef AUTO_INC_EN
          ptr         <= ptr + 1'b1;
`endif
        end
        WAIT_REL: begin
          db_cnt <= '0;
          if (!press_s) state <= DB_REL;
        end
        DB_REL: begin
          if (press_s) begin
            state  <= WAIT_REL;
            db_cnt <= '0;
          end else if (db_cnt == DB_MAX) begin
            state  <= IDLE;
            busy   <= 1'b0;
            db_cnt <= '0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          db_cnt <= '0;
        end
      endcase
    end
  end

endmodule
